// File: rtl/mem_pkg.sv
// Shared definitions for the memory-mode controller.
//   mem_state_e   : controller FSM state encoding (IDLE / HOLD / RUN).
//   SEL_IDLE      : select code meaning "no master granted".
//   sel_is_master : true when a select code names a real master (1..n_masters).
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHold = 2'd1,
        StRun  = 2'd2
    } mem_state_e;

    localparam int unsigned SEL_IDLE = 0;

    // Codes above the master count are treated like SEL_IDLE.
    function automatic logic sel_is_master(input int unsigned sel,
                                           input int unsigned n_masters);
        return (sel != SEL_IDLE) && (sel <= n_masters);
    endfunction

endpackage

// File: rtl/sel_debounce.sv
// Synchronizer and debouncer for the asynchronous mode-select input.
// A new value is accepted only after DEB_CYC consecutive equal synchronized
// samples; any change restarts the count. The accepted value resets to 0.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   i_sel  : raw asynchronous select
//   o_sel  : debounced, accepted select
module sel_debounce #(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned DEB_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] i_sel,
    output logic [SEL_W-1:0] o_sel
);

    localparam int unsigned     CNT_W   = $clog2(DEB_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC);

    logic [SEL_W-1:0] r_sync1;
    logic [SEL_W-1:0] r_sync2;
    logic [SEL_W-1:0] r_cand;
    logic [SEL_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic             w_changed;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [SEL_W-1:0] w_acc_nxt;

    always_comb begin
        w_changed = (r_sync2 != r_cand);
        // r_cnt holds the number of consecutive equal samples seen so far,
        // saturating at DEB_CYC; a change counts as the first new sample.
        if (w_changed) begin
            w_cnt_nxt = CNT_W'(1);
        end else if (r_cnt == CNT_MAX) begin
            w_cnt_nxt = r_cnt;
        end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        w_acc_nxt = (w_cnt_nxt == CNT_MAX) ? r_sync2 : r_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_cand  <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else begin
            r_sync1 <= i_sel;
            r_sync2 <= r_sync1;
            r_cand  <= r_sync2;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    assign o_sel = r_acc;

endmodule

// File: rtl/mem_mode_ctrl.sv
// Mode controller granting one of N_MASTERS bus masters access to a shared
// dual-port BRAM. A debounced select chooses the master; every mode change
// passes through HOLD, where all master resets are held for HOLD_CYC cycles.
// The BRAM address/data path is a purely combinational mux, zeroed outside RUN.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   sel               : async mode select (0 idle, k = master k-1, >N idle)
//   m_addra / m_addrb : packed per-master port-A/B byte addresses
//   m_wea / m_web     : packed per-master byte write enables
//   m_dia / m_dib     : packed per-master write data
//   row_a / row_b     : BRAM word-row addresses
//   wea / web         : BRAM byte write enables
//   dia / dib         : BRAM write data
//   m_rst_n           : per-master active-low reset
//   clk_rst           : active-high clock-generator reset
//   active            : currently granted mode (0 outside RUN)
//   busy              : high whenever not in RUN
module mem_mode_ctrl
    import mem_pkg::*;
#(
    parameter  int unsigned N_MASTERS = 2,
    parameter  int unsigned ADDR_W    = 16,
    parameter  int unsigned ROW_W     = 13,
    parameter  int unsigned DATA_W    = 32,
    parameter  int unsigned DEB_CYC   = 16,
    parameter  int unsigned HOLD_CYC  = 8,
    localparam int unsigned SEL_W     = $clog2(N_MASTERS + 1),
    localparam int unsigned BE_W      = DATA_W / 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SEL_W-1:0]            sel,
    input  logic [N_MASTERS*ADDR_W-1:0] m_addra,
    input  logic [N_MASTERS*ADDR_W-1:0] m_addrb,
    input  logic [N_MASTERS*BE_W-1:0]   m_wea,
    input  logic [N_MASTERS*BE_W-1:0]   m_web,
    input  logic [N_MASTERS*DATA_W-1:0] m_dia,
    input  logic [N_MASTERS*DATA_W-1:0] m_dib,
    output logic [ROW_W-1:0]            row_a,
    output logic [ROW_W-1:0]            row_b,
    output logic [BE_W-1:0]             wea,
    output logic [BE_W-1:0]             web,
    output logic [DATA_W-1:0]           dia,
    output logic [DATA_W-1:0]           dib,
    output logic [N_MASTERS-1:0]        m_rst_n,
    output logic                        clk_rst,
    output logic [SEL_W-1:0]            active,
    output logic                        busy
);

    localparam int unsigned      HCNT_W    = $clog2(HOLD_CYC + 1);
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLD_CYC - 1);

    // ------------------------------------------------------------------
    // Select synchronizer + debounce
    // ------------------------------------------------------------------
    logic [SEL_W-1:0] w_sel_acc;
    logic             w_acc_valid;

    sel_debounce #(
        .SEL_W   (SEL_W),
        .DEB_CYC (DEB_CYC)
    ) u_sel_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .i_sel (sel),
        .o_sel (w_sel_acc)
    );

    assign w_acc_valid = sel_is_master(32'(w_sel_acc), N_MASTERS);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    mem_state_e        r_state;
    mem_state_e        w_state_nxt;
    logic [SEL_W-1:0]  r_target;
    logic [SEL_W-1:0]  w_target_nxt;
    logic [SEL_W-1:0]  r_active;
    logic [SEL_W-1:0]  w_active_nxt;
    logic [HCNT_W-1:0] r_hcnt;
    logic [HCNT_W-1:0] w_hcnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_target <= '0;
            r_active <= '0;
            r_hcnt   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
            r_active <= w_active_nxt;
            r_hcnt   <= w_hcnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_active_nxt = r_active;
        w_hcnt_nxt   = r_hcnt;

        unique case (r_state)
            StIdle: begin
                if (w_acc_valid) begin
                    w_state_nxt  = StHold;
                    w_target_nxt = w_sel_acc;
                    w_hcnt_nxt   = '0;
                end
            end

            StHold: begin
                if (!w_acc_valid) begin
                    w_state_nxt  = StIdle;
                    w_target_nxt = '0;
                    w_hcnt_nxt   = '0;
                end else if (w_sel_acc != r_target) begin
                    // Retarget: the new master gets a full hold period.
                    w_target_nxt = w_sel_acc;
                    w_hcnt_nxt   = '0;
                end else if (r_hcnt == HCNT_LAST) begin
                    w_state_nxt  = StRun;
                    w_active_nxt = r_target;
                    w_hcnt_nxt   = '0;
                end else begin
                    w_hcnt_nxt = r_hcnt + HCNT_W'(1);
                end
            end

            StRun: begin
                if (!w_acc_valid) begin
                    w_state_nxt  = StIdle;
                    w_target_nxt = '0;
                    w_active_nxt = '0;
                end else if (w_sel_acc != r_active) begin
                    w_state_nxt  = StHold;
                    w_target_nxt = w_sel_acc;
                    w_active_nxt = '0;
                    w_hcnt_nxt   = '0;
                end
            end

            default: begin
                w_state_nxt  = StIdle;
                w_target_nxt = '0;
                w_active_nxt = '0;
                w_hcnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and BRAM mux
    // ------------------------------------------------------------------
    // Everything below depends on r_state directly, so write enables drop in
    // the very cycle the FSM leaves RUN and an async reset clears them at once.
    always_comb begin
        row_a   = '0;
        row_b   = '0;
        wea     = '0;
        web     = '0;
        dia     = '0;
        dib     = '0;
        m_rst_n = '0;
        clk_rst = (r_state == StIdle);
        busy    = (r_state != StRun);
        active  = r_active;

        if (r_state == StRun) begin
            for (int i = 0; i < int'(N_MASTERS); i++) begin
                if (r_active == SEL_W'(i + 1)) begin
                    // Byte address to word row, upper bits dropped.
                    row_a      = ROW_W'(m_addra[i*ADDR_W +: ADDR_W] >> 2);
                    row_b      = ROW_W'(m_addrb[i*ADDR_W +: ADDR_W] >> 2);
                    wea        = m_wea[i*BE_W +: BE_W];
                    web        = m_web[i*BE_W +: BE_W];
                    dia        = m_dia[i*DATA_W +: DATA_W];
                    dib        = m_dib[i*DATA_W +: DATA_W];
                    m_rst_n[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/mem_mode_ctrl.md
MEM_MODE_CTRL -- requirements
Module: mem_mode_ctrl

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2, number of bus masters sharing the dual-port BRAM.
REQ-002 SHALL have parameter ADDR_W, default 16, master byte-address width.
REQ-003 SHALL have parameter ROW_W, default 13, BRAM word-row width.
REQ-004 SHALL have parameter DATA_W, default 32, data width; byte enables are DATA_W/8 wide (BE_W).
REQ-005 SHALL have parameter DEB_CYC, default 16, cycles a select value must be stable before acceptance.
REQ-006 SHALL have parameter HOLD_CYC, default 8, cycles all master resets are held during a mode change.
REQ-007 SHALL have SEL_W = clog2(N_MASTERS+1), a derived localparam.
REQ-008 Ports (name, direction, width, meaning):
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- sel  in  SEL_W  asynchronous mode switch; 0 = idle, k = master k-1, values above N_MASTERS = idle.
- m_addra / m_addrb  in  N_MASTERS*ADDR_W  packed port-A/B byte addresses, master i at slice i.
- m_wea / m_web  in  N_MASTERS*BE_W  packed byte write enables.
- m_dia / m_dib  in  N_MASTERS*DATA_W  packed write data.
- row_a / row_b  out  ROW_W  BRAM row addresses.
- wea / web  out  BE_W  BRAM byte write enables.
- dia / dib  out  DATA_W  BRAM write data.
- m_rst_n  out  N_MASTERS  per-master active-low reset.
- clk_rst  out  1  active-high clock-generator reset.
- active  out  SEL_W  currently granted mode.
- busy  out  1  high in any state other than RUN.

Function
REQ-009 sel SHALL pass a 2-flop synchronizer before any use.
REQ-010 Synchronized sel SHALL be accepted only after DEB_CYC consecutive equal samples; a counter restarts on any change.
REQ-011 FSM states SHALL be IDLE, HOLD, RUN.
REQ-012 IDLE: clk_rst=1, m_rst_n all 0, active=0; an accepted sel k>0 moves to HOLD with target k.
REQ-013 HOLD: clk_rst=0, m_rst_n all 0, hold counter counts HOLD_CYC cycles, then RUN with active=target.
REQ-014 RUN: m_rst_n[active-1]=1, all other bits 0, clk_rst=0.
REQ-015 RUN with accepted sel equal to active SHALL remain in RUN.
REQ-016 RUN with accepted sel differing from active and nonzero SHALL go to HOLD with the new target; accepted sel 0 SHALL go to IDLE.
REQ-017 An accepted sel change during HOLD SHALL retarget and restart the hold counter; accepted 0 SHALL go to IDLE.
REQ-018 In RUN, row_a SHALL equal m_addra slice[active-1] >> 2, truncated to ROW_W; row_b likewise from m_addrb.
REQ-019 In RUN, wea/web/dia/dib SHALL combinationally forward the active master's slices.
REQ-020 Outside RUN, row_a, row_b, wea, web, dia, and dib SHALL all be 0, so no write can occur.
REQ-021 Write enables SHALL be forced to 0 in the first cycle the FSM leaves RUN (combinational on state).
REQ-022 Latency from a sel edge to the first RUN cycle SHALL be 2 + DEB_CYC + HOLD_CYC cycles, ±1.

Reset
REQ-023 On rst_n=0, state SHALL be IDLE, counters and synchronizer 0, active=0, clk_rst=1, m_rst_n=0, busy=1.
REQ-024 Reset asserted mid-HOLD or mid-RUN SHALL take effect immediately (asynchronous), with the REQ-023 values.

Structure
REQ-025 State encodings and the IDLE select code SHALL reside in shared package mem_pkg.
REQ-026 Synchronizer plus debounce SHALL be sub-module sel_debounce (parameters SEL_W, DEB_CYC).
REQ-027 The output mux SHALL be pure combinational logic, with no registers on the address or data path.

Verification
REQ-028 Setup N_MASTERS=2, DEB_CYC=4, HOLD_CYC=3: sel 0->1 -> m_rst_n=2'b01 and active=1 after ≤10 cycles; m_addra[15:0]=0x0010 -> row_a=0x004.
REQ-029 RUN master 0, then sel 1->2 -> web=0 the next accepted cycle, m_rst_n=00 for 3 cycles, then m_rst_n=2'b10 and master 1's 0x1FFC -> row_b=0x7FF.
REQ-030 sel glitches 1->2->1 within 3 cycles -> no transition, active stays 1, busy stays 0.
REQ-031 sel=3 (out of range) -> IDLE, clk_rst=1, all outputs 0.
REQ-032 rst_n pulsed low mid-RUN with m_web=4'hF -> web=0 and m_rst_n=00 in the same cycle; re-run REQ-028 latency after release.
REQ-033 Address 0xFFFF with ROW_W=13 -> row=0x1FFF (truncation check).
